bin_act_pack: RTL and testbench



---
 rtl/bin_act_pack_if.sv | 28 ++
 rtl/bin_act_pack.sv | 185 ++++++++++++++++++
 tb/tb_bin_act_pack.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bin_act_pack_if.sv
// bin_act_pack_if: stream bundle around the binarizing packer.
// Carries the pooled 16-bit sample stream into the block and the
// packed-byte valid/ready stream out to the next binary conv layer.
interface bin_act_pack_if;
  logic        ivalid;
  logic [15:0] din;
  logic        ovalid;
  logic        oready;
  logic [7:0]  dout;

  // Producer/consumer environment side
  modport master (
    output ivalid,
    output din,
    output oready,
    input  ovalid,
    input  dout
  );

  // The packer itself
  modport slave (
    input  ivalid,
    input  din,
    input  oready,
    output ovalid,
    output dout
  );
endinterface

// File: rtl/bin_act_pack.sv
// bin_act_pack: binarizing activation and LSB-first bit packer placed
// after the 2x2 max-pool stage. Each pooled sample becomes one bit, eight
// bits form a byte, and bytes queue in a small FIFO toward the next layer.
//
// Build option: define BIN_ACT_PACK_THRESH_EN to compare each sample with
// the per-channel thresh port. Without it the thresh port is ignored and
// the bit is the pure sign test (din >= 0); the channel index still counts.
module bin_act_pack #(
  parameter int FIFO_DEPTH = 4,
  parameter int CH_L0      = 6,
  parameter int CH_L1      = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          state,
  input  logic [15:0]   thresh,
  output logic [3:0]    ch_idx,
  output logic          frame_done,
  output logic          overflow,
  bin_act_pack_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Last pixel index of a map: 12x12 pooled map or 4x4 pooled map
  localparam logic [7:0] MAP0_LAST = 8'd143;
  localparam logic [7:0] MAP1_LAST = 8'd15;
  localparam logic [3:0] CH0_LAST  = 4'(CH_L0 - 1);
  localparam logic [3:0] CH1_LAST  = 4'(CH_L1 - 1);

  logic                mode_q, mode_d;
  logic [7:0]          pix_q, pix_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic [3:0]          ch_q, ch_d;
  logic                frame_done_q, frame_done_d;
  logic                overflow_q, overflow_d;
  logic [PTR_W-1:0]    wr_q, wr_d;
  logic [PTR_W-1:0]    rd_q, rd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [7:0]          mem_d [FIFO_DEPTH];
  logic                ovalid_q, ovalid_d;
  logic [7:0]          dout_q, dout_d;

  logic signed [15:0]  cmp_ref;
  logic                act_bit;
  logic                push;
  logic                push_ok;
  logic                pop;
  logic [7:0]          new_byte;
  logic [7:0]          map_last;
  logic [3:0]          ch_last;

`ifdef BIN_ACT_PACK_THRESH_EN
  assign cmp_ref = $signed(thresh);
`else
  // The port stays on the block so both builds share one pin list; its
  // value is masked off so the compare reduces to a sign test.
  assign cmp_ref = $signed(thresh & 16'h0000);
`endif

  assign act_bit  = ($signed(bus.din) >= cmp_ref);
  assign map_last = mode_q ? MAP1_LAST : MAP0_LAST;
  assign ch_last  = mode_q ? CH1_LAST : CH0_LAST;

  // Next-state logic: mode latch, bit/pixel/channel counters, packing and FIFO
  always_comb begin
    mode_d       = mode_q;
    pix_d        = pix_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    ch_d         = ch_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    mem_d        = mem_q;
    push         = 1'b0;
    push_ok      = 1'b0;
    pop          = 1'b0;
    new_byte     = shift_q;
    new_byte[7]  = act_bit;

    // Layer mode may only change between maps; mid-map toggles wait
    if ((pix_q == 8'd0) && (bit_q == 3'd0)) begin
      mode_d = state;
    end

    if (bus.ivalid) begin
      if (bit_q == 3'd7) begin
        push    = 1'b1;
        bit_d   = 3'd0;
        shift_d = 8'h00;
      end else begin
        bit_d          = bit_q + 3'd1;
        shift_d[bit_q] = act_bit;
      end

      if (pix_q == map_last) begin
        pix_d = 8'd0;
        if (ch_q >= ch_last) begin
          ch_d         = 4'd0;
          frame_done_d = 1'b1;
        end else begin
          ch_d = ch_q + 4'd1;
        end
      end else begin
        pix_d = pix_q + 8'd1;
      end
    end

    pop = (cnt_q != '0) && bus.oready;
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end

    // A full FIFO still takes a byte if the head leaves on the same edge
    if (push) begin
      if ((cnt_q != FULL_CNT) || pop) begin
        push_ok     = 1'b1;
        mem_d[wr_q] = new_byte;
        wr_d        = wr_q + 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    ovalid_d = (cnt_d != '0);
    dout_d   = mem_d[rd_d];
  end

  // State registers; reset discards any partial byte and flushes the FIFO
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q       <= 1'b0;
      pix_q        <= 8'd0;
      bit_q        <= 3'd0;
      shift_q      <= 8'h00;
      ch_q         <= 4'd0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      ovalid_q     <= 1'b0;
      dout_q       <= 8'h00;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      mode_q       <= mode_d;
      pix_q        <= pix_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      ch_q         <= ch_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      ovalid_q     <= ovalid_d;
      dout_q       <= dout_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bus.ovalid = ovalid_q;
  assign bus.dout   = dout_q;
  assign ch_idx     = ch_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_bin_act_pack.sv
// tb_bin_act_pack: self-checking bench for bin_act_pack.
// Expected bytes are assembled from the expected activation bits of each
// stimulus and queued; they are compared as the DUT presents its FIFO head.
module tb_bin_act_pack;

  localparam int FIFO_DEPTH = 4;
  localparam int CH_L0      = 6;
  localparam int CH_L1      = 12;

  logic        clk;
  logic        rstn;
  logic        state;
  logic [15:0] thresh;
  logic [3:0]  ch_idx;
  logic        frame_done;
  logic        overflow;

  bin_act_pack_if bus ();

  bin_act_pack #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CH_L0      (CH_L0),
    .CH_L1      (CH_L1)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .state      (state),
    .thresh     (thresh),
    .ch_idx     (ch_idx),
    .frame_done (frame_done),
    .overflow   (overflow),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] din;
    logic               exp_bit;
  } vec_t;

  int          errors;
  int          checks;
  logic [7:0]  exp_q [$];
  int          pix_m;
  int          bit_m;
  int          ch_m;
  logic        mode_m;
  logic        fd_exp;
  logic        ovf_m;
  logic [7:0]  acc_m;
  int          drained;
  int          fd_seen;
  int          ch_max;

  task automatic checkEq(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Per-cycle comparison of every output against the reference state
  task automatic checkOutput();
    checkEq("ovalid", int'(bus.ovalid), int'(exp_q.size() != 0));
    if (exp_q.size() != 0) checkEq("dout", int'(bus.dout), int'(exp_q[0]));
    checkEq("ch_idx", int'(ch_idx), ch_m);
    checkEq("frame_done", int'(frame_done), int'(fd_exp));
    checkEq("overflow", int'(overflow), int'(ovf_m));
    if (frame_done) fd_seen++;
    if (int'(ch_idx) > ch_max) ch_max = int'(ch_idx);
  endtask

  // One clock: drive inputs, check current outputs, advance the reference
  task automatic applyStimulus(input logic iv, input logic signed [15:0] d,
                               input logic signed [15:0] th, input logic rdy,
                               input logic st, input logic eb);
    logic boundary;
    @(negedge clk);
    bus.ivalid = iv;
    bus.din    = d;
    thresh     = th;
    bus.oready = rdy;
    state      = st;
    checkOutput();
    if ((exp_q.size() != 0) && rdy) begin
      void'(exp_q.pop_front());
      drained++;
    end
    fd_exp   = 1'b0;
    boundary = (pix_m == 0) && (bit_m == 0);
    if (iv) begin
      acc_m[bit_m] = eb;
      if (bit_m == 7) begin
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(acc_m);
        else ovf_m = 1'b1;
        bit_m = 0;
        acc_m = 8'h00;
      end else begin
        bit_m++;
      end
      if (pix_m == (mode_m ? 15 : 143)) begin
        pix_m = 0;
        if (ch_m == (mode_m ? CH_L1 - 1 : CH_L0 - 1)) begin
          ch_m   = 0;
          fd_exp = 1'b1;
        end else begin
          ch_m++;
        end
      end else begin
        pix_m++;
      end
    end
    if (boundary) mode_m = st;
  endtask

  task automatic idle(input int n, input logic rdy, input logic st);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'sd0, 16'sd0, rdy, st, 1'b0);
  endtask

  // Wait just past the edge of the last driven step for explicit checks
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rstn       = 1'b0;
    bus.ivalid = 1'b0;
    bus.din    = 16'h0000;
    bus.oready = 1'b0;
    thresh     = 16'h0000;
    state      = 1'b0;
    exp_q.delete();
    pix_m   = 0;
    bit_m   = 0;
    ch_m    = 0;
    mode_m  = 1'b0;
    fd_exp  = 1'b0;
    ovf_m   = 1'b0;
    acc_m   = 8'h00;
    drained = 0;
    fd_seen = 0;
    ch_max  = 0;
    #1;
    checkEq("rst_ovalid", int'(bus.ovalid), 0);
    checkEq("rst_dout", int'(bus.dout), 0);
    checkEq("rst_ch_idx", int'(ch_idx), 0);
    checkEq("rst_frame_done", int'(frame_done), 0);
    checkEq("rst_overflow", int'(overflow), 0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  vec_t vecs [16];

  initial begin
    logic signed [15:0] d;
    errors = 0;
    checks = 0;
    rstn   = 1'b0;
    state  = 1'b0;
    thresh = 16'h0000;
    bus.ivalid = 1'b0;
    bus.din    = 16'h0000;
    bus.oready = 1'b0;

    // 5,-3,0,-1,7,-8,2,-2 -> 0x55 ; extremes and zero -> 0x4D
    vecs[0]  = '{16'sd5, 1'b1};      vecs[1]  = '{-16'sd3, 1'b0};
    vecs[2]  = '{16'sd0, 1'b1};      vecs[3]  = '{-16'sd1, 1'b0};
    vecs[4]  = '{16'sd7, 1'b1};      vecs[5]  = '{-16'sd8, 1'b0};
    vecs[6]  = '{16'sd2, 1'b1};      vecs[7]  = '{-16'sd2, 1'b0};
    vecs[8]  = '{16'sh7FFF, 1'b1};   vecs[9]  = '{16'sh8000, 1'b0};
    vecs[10] = '{16'sd1, 1'b1};      vecs[11] = '{16'sd0, 1'b1};
    vecs[12] = '{-16'sd1, 1'b0};     vecs[13] = '{-16'sd2, 1'b0};
    vecs[14] = '{16'sd100, 1'b1};    vecs[15] = '{-16'sd100, 1'b0};

    $display("[TB] start");
    resetDut();

    // Table vectors, mode 0, thresh 0, consumer always ready
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, vecs[i].din, 16'sd0, 1'b1, 1'b0, vecs[i].exp_bit);
      if (i == 7) begin
        settle();
        checkEq("latency_ovalid", int'(bus.ovalid), 1);
        checkEq("first_byte", int'(bus.dout), 8'h55);
      end
    end
    idle(4, 1'b1, 1'b0);
    checkEq("table_bytes", drained, 2);

    // Mode 1 full frame: 12 channels x 16 px, every bit set
    resetDut();
    idle(2, 1'b1, 1'b1);
    for (int i = 0; i < 192; i++) applyStimulus(1'b1, 16'sd100, 16'sd50, 1'b1, 1'b1, 1'b1);
    idle(4, 1'b1, 1'b1);
    checkEq("m1_bytes", drained, 24);
    checkEq("m1_frame_done_pulses", fd_seen, 1);
    checkEq("m1_ch_max", ch_max, 11);
    checkEq("m1_ch_wrap", int'(ch_idx), 0);

    // Overflow: five bytes into a four-entry FIFO with no consumer
    resetDut();
    for (int i = 0; i < 40; i++) begin
      d = 16'($urandom);
      applyStimulus(1'b1, d, 16'sd0, 1'b0, 1'b0, d >= 16'sd0);
    end
    idle(1, 1'b0, 1'b0);
    checkEq("ovf_set", int'(overflow), 1);
    idle(10, 1'b1, 1'b0);
    checkEq("ovf_drained", drained, 4);
    checkEq("ovf_sticky", int'(overflow), 1);
    checkEq("ovf_empty", int'(bus.ovalid), 0);

    // Full FIFO with push and pop on the same edge
    resetDut();
    for (int i = 0; i < 39; i++) begin
      d = 16'($urandom);
      applyStimulus(1'b1, d, 16'sd0, 1'b0, 1'b0, d >= 16'sd0);
    end
    drained = 0;
    applyStimulus(1'b1, 16'sd9, 16'sd0, 1'b1, 1'b0, 1'b1);
    idle(10, 1'b1, 1'b0);
    checkEq("pp_no_overflow", int'(overflow), 0);
    checkEq("pp_drained", drained, 5);

    // Mode change mid-map waits for the map boundary
    resetDut();
    idle(1, 1'b1, 1'b0);
    for (int i = 0; i < 144; i++)
      applyStimulus(1'b1, 16'sd1, 16'sd0, 1'b1, (i >= 40), 1'b1);
    settle();
    checkEq("mode_hold_ch", int'(ch_idx), 1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, -16'sd1, 16'sd0, 1'b1, 1'b1, 1'b0);
    settle();
    checkEq("mode_next_map_ch", int'(ch_idx), 2);
    idle(4, 1'b1, 1'b1);

    // Reset mid-byte leaves no stale bits behind
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'sd1, 16'sd0, 1'b1, 1'b0, 1'b1);
    resetDut();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, -16'sd1, 16'sd0, 1'b0, 1'b0, 1'b0);
    settle();
    checkEq("rst_mid_ovalid", int'(bus.ovalid), 1);
    checkEq("rst_mid_byte", int'(bus.dout), 8'h00);
    idle(3, 1'b1, 1'b0);
    checkEq("rst_mid_count", drained, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
